// File: rtl/dma_sched_pkg.sv
// Shared types for the CPU / OAM DMA / DPCM DMA bus scheduler.
// Optional statistics are enabled by DMA_SCHED_STATS_EN.
`timescale 1ns/1ps

package dma_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      OAM_GET,
      OAM_PUT,
      DMC_GET,
      REALIGN
   } state_t;

   typedef enum logic {
      GET = 1'b0,
      PUT = 1'b1
   } phase_t;

   localparam int          OAM_LEN_DEF      = 256;
   localparam logic [15:0] OAMDATA_ADDR_DEF = 16'h2004;

   function automatic logic is_waste(state_t s);
      return (s == ALIGN) || (s == REALIGN);
   endfunction

endpackage

// File: rtl/dma_addr_mux.sv
// External address / strobe mux: the CPU owns the pads unless
// a DMA get or put cycle is in progress.
`timescale 1ns/1ps

module dma_addr_mux
   import dma_sched_pkg::*;
#(
   parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEF
) (
   input  state_t      state,
   input  logic [7:0]  page,
   input  logic [7:0]  count,
   input  logic        rnw,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] dmc_addr,
   output logic [15:0] addr,
   output logic        rd,
   output logic        wr,
   output logic        spr
);

   always_comb begin
      addr = cpu_addr;
      rd   = 1'b0;
      wr   = 1'b0;
      spr  = 1'b0;
      unique case (1'b1)
         (state == OAM_GET): begin
            addr = {page, count};
            rd   = 1'b1;
         end
         (state == DMC_GET): begin
            addr = dmc_addr;
            rd   = 1'b1;
         end
         (state == OAM_PUT): begin
            addr = OAMDATA_ADDR;
            wr   = 1'b1;
            spr  = 1'b1;
         end
         // halted CPU keeps repeating its own read
         (state == HALT),
         (state == ALIGN): begin
            rd = rnw;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dma_bus_sched.sv
// Bus scheduler: owns RDY, interleaves OAM get/put pairs and DPCM reads.
// Define DMA_SCHED_STATS_EN to add the STAT_STEAL / STAT_WASTE counters.
`timescale 1ns/1ps

module dma_bus_sched
   import dma_sched_pkg::*;
#(
   parameter int          OAM_LEN      = OAM_LEN_DEF,
   parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEF
) (
   input  logic        CLK,
   input  logic        n_RES,
   input  logic        RnW,
   input  logic        W4014,
   input  logic [7:0]  DB,
   input  logic [15:0] CPU_Addr,
   input  logic [15:0] DMC_Addr,
   input  logic        DMC_REQ,
   output logic        DMC_ACK,
   output logic        RDY,
   output logic [15:0] Addr,
   output logic        RD,
   output logic        WR,
   output logic        SPR_PPU,
   output logic        BUSY
`ifdef DMA_SCHED_STATS_EN
   ,
   output logic [15:0] STAT_STEAL,
   output logic [15:0] STAT_WASTE
`endif
);

   localparam int CW = $clog2(OAM_LEN + 1);

   state_t        state;
   state_t        state_nx;
   state_t        get_tgt;
   phase_t        phase;
   logic [7:0]    page;
   logic [CW-1:0] count;
   logic          oam_pend;
   logic          take_oam;
   logic          last_put;

   assign take_oam = W4014 & ~oam_pend;
   assign last_put = (state == OAM_PUT) &&
                     (count == CW'(OAM_LEN - 1));

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         phase <= GET;
      end else begin
         phase <= (phase == GET) ? PUT : GET;
      end
   end

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // DPCM wins every GET-phase decision point
   always_comb begin
      get_tgt = IDLE;
      if (DMC_REQ) begin
         get_tgt = DMC_GET;
      end else if (oam_pend) begin
         get_tgt = OAM_GET;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (W4014 | oam_pend | DMC_REQ) begin
               state_nx = HALT;
            end
         end
         HALT: begin
            if (RnW) begin
               state_nx = (phase == PUT) ? get_tgt : ALIGN;
            end
         end
         ALIGN: begin
            if (phase == PUT) begin
               state_nx = get_tgt;
            end
         end
         OAM_GET: begin
            state_nx = OAM_PUT;
         end
         OAM_PUT: begin
            if (last_put) begin
               state_nx = IDLE;
            end else begin
               state_nx = DMC_REQ ? DMC_GET : OAM_GET;
            end
         end
         DMC_GET: begin
            state_nx = oam_pend ? REALIGN : IDLE;
         end
         REALIGN: begin
            state_nx = DMC_REQ ? DMC_GET : OAM_GET;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_comb begin
      RDY     = (state == IDLE);
      DMC_ACK = (state == DMC_GET);
      BUSY    = (state != IDLE) | oam_pend | DMC_REQ;
   end

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         page     <= '0;
         count    <= '0;
         oam_pend <= 1'b0;
      end else if (take_oam) begin
         page     <= DB;
         count    <= '0;
         oam_pend <= 1'b1;
      end else if (state == OAM_PUT) begin
         if (last_put) begin
            count    <= '0;
            oam_pend <= 1'b0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   dma_addr_mux #(
      .OAMDATA_ADDR (OAMDATA_ADDR)
   ) u_mux (
      .state    (state),
      .page     (page),
      .count    (count[7:0]),
      .rnw      (RnW),
      .cpu_addr (CPU_Addr),
      .dmc_addr (DMC_Addr),
      .addr     (Addr),
      .rd       (RD),
      .wr       (WR),
      .spr      (SPR_PPU)
   );

`ifdef DMA_SCHED_STATS_EN
   logic steal_hit;
   logic waste_hit;

   assign steal_hit = (state == DMC_GET) && oam_pend;
   assign waste_hit = is_waste(state);

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         STAT_STEAL <= '0;
         STAT_WASTE <= '0;
      end else begin
         if (steal_hit && (STAT_STEAL != 16'hFFFF)) begin
            STAT_STEAL <= STAT_STEAL + 16'd1;
         end
         if (waste_hit && (STAT_WASTE != 16'hFFFF)) begin
            STAT_WASTE <= STAT_WASTE + 16'd1;
         end
      end
   end
`endif

endmodule
